// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: multi-digit 7-segment controller for the board HEX displays.
// Captures a packed hex value on load, decodes each nibble to a 0-F glyph, and
// supports leading-zero blanking and per-digit blinking. Segment outputs are registered.
// Optional feature: define HEX_DP_EN to add per-digit decimal points (8 bits per digit).
module hex_display_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
`ifdef HEX_DP_EN
  input  logic [NUM_DIGITS-1:0]   dp,
`endif
  input  logic                    blank_lz,
  input  logic                    blink_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`ifdef HEX_DP_EN
  output logic [8*NUM_DIGITS-1:0] hex_out,
`else
  output logic [7*NUM_DIGITS-1:0] hex_out,
`endif
  output logic                    blink_phase,
  output logic                    disp_valid
);

`ifdef HEX_DP_EN
  localparam int DW = 8;
`else
  localparam int DW = 7;
`endif
  localparam int PW = $clog2(BLINK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(BLINK_DIV - 1);
  // Every segment (and DP) unlit in board polarity.
  localparam logic [DW*NUM_DIGITS-1:0] DARK = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [4*NUM_DIGITS-1:0]  value_q;
  logic                     valid_q;
  logic [PW-1:0]            presc_q, presc_d;
  logic                     phase_q, phase_d;
  logic [DW*NUM_DIGITS-1:0] hex_q, hex_d;
`ifdef HEX_DP_EN
  logic [NUM_DIGITS-1:0]    dp_q;
`endif

  // Active-high gfedcba glyph for one nibble.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;  4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;  4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;  4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;  4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  // Capture stage: value (and DP) latch on load; valid flag sticks until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
      valid_q <= 1'b0;
`ifdef HEX_DP_EN
      dp_q    <= '0;
`endif
    end else if (load) begin
      value_q <= value;
      valid_q <= 1'b1;
`ifdef HEX_DP_EN
      dp_q    <= dp;
`endif
    end
  end

  // Blink prescaler: wraps at BLINK_DIV-1 and flips the phase; held at zero when disabled.
  always_comb begin
    presc_d = '0;
    phase_d = 1'b0;
    if (blink_en) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        phase_d = ~phase_q;
      end else begin
        presc_d = presc_q + 1'b1;
        phase_d = phase_q;
      end
    end
  end

  // Prescaler / phase state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      phase_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      phase_q <= phase_d;
    end
  end

  // Segment decode: scan from the top digit tracking the all-zero run for blanking.
  always_comb begin
    logic                  zrun;
    logic                  lz_dark;
    logic                  hard_dark;
    logic [DW-1:0]         seg;
    hex_d     = '0;
    zrun      = 1'b1;
    lz_dark   = 1'b0;
    hard_dark = 1'b0;
    seg       = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zrun      = zrun && (value_q[4*i +: 4] == 4'h0);
      lz_dark   = blank_lz && zrun && (i != 0);
      // Blink and invalid display also kill the DP; blanking does not.
      hard_dark = !valid_q || (blink_en && phase_q && blink_mask[i]);
      seg       = '0;
      if (!(hard_dark || lz_dark)) seg[6:0] = glyph(value_q[4*i +: 4]);
`ifdef HEX_DP_EN
      seg[7]    = dp_q[i] && !hard_dark;
`endif
      hex_d[DW*i +: DW] = (ACTIVE_LOW != 0) ? ~seg : seg;
    end
  end

  // Output segment register.
  always_ff @(posedge clk) begin
    if (reset) hex_q <= DARK;
    else       hex_q <= hex_d;
  end

  assign hex_out     = hex_q;
  assign blink_phase = phase_q;
  assign disp_valid  = valid_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl (6 digits, BLINK_DIV=4, active-low, no DP).
// A cycle model predicts each edge's outputs into a queue; the post-edge sample pops them.
module tb_hex_display_ctrl;
  localparam int ND = 6;
  localparam int BD = 4;

  logic          clk = 1'b0;
  logic          reset, load, blank_lz, blink_en;
  logic [23:0]   value;
  logic [5:0]    blink_mask;
  logic [41:0]   hex_out;
  logic          blink_phase, disp_valid;

  int total = 0;
  int bad   = 0;

  // Active-high gfedcba glyphs 0..F.
  localparam logic [6:0] GLY [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // model state
  logic [23:0] m_val   = '0;
  logic        m_valid = 1'b0;
  int          m_presc = 0;
  logic        m_phase = 1'b0;
  logic [41:0] m_hex   = '1;
  logic [43:0] sbq[$];

  hex_display_ctrl #(.NUM_DIGITS(ND), .BLINK_DIV(BD), .ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .blank_lz(blank_lz),
    .blink_en(blink_en), .blink_mask(blink_mask), .hex_out(hex_out),
    .blink_phase(blink_phase), .disp_valid(disp_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] dig(input int i);
    return hex_out[7*i +: 7];
  endfunction

  // A digit is blanked as a leading zero when it and everything above it is zero.
  function automatic logic [41:0] exp_hex(input logic [23:0] v, input logic vld, input logic blz,
                                          input logic ben, input logic [5:0] msk, input logic ph);
    logic [41:0] r;
    logic        dark;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      dark = !vld || (ben && ph && msk[i]) || (blz && i > 0 && (v >> (4*i)) == 24'd0);
      r[7*i +: 7] = dark ? 7'h7F : ~GLY[v[4*i +: 4]];
    end
    return r;
  endfunction

  // One clock: predict, push, clock, pop and compare.
  task automatic step();
    logic [43:0] e;
    if (reset) begin
      m_hex = '1; m_val = '0; m_valid = 1'b0; m_presc = 0; m_phase = 1'b0;
    end else begin
      m_hex = exp_hex(m_val, m_valid, blank_lz, blink_en, blink_mask, m_phase);
      if (load) begin m_val = value; m_valid = 1'b1; end
      if (blink_en) begin
        if (m_presc == BD - 1) begin m_presc = 0; m_phase = ~m_phase; end
        else m_presc++;
      end else begin
        m_presc = 0; m_phase = 1'b0;
      end
    end
    sbq.push_back({m_hex, m_phase, m_valid});
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("sb_hex",   64'(hex_out),     64'(e[43:2]));
    chk("sb_phase", 64'(blink_phase), 64'(e[1]));
    chk("sb_valid", 64'(disp_valid),  64'(e[0]));
  endtask

  initial begin
    reset = 1'b1; load = 1'b1; value = 24'hFFFFFF; blank_lz = 1'b0;
    blink_en = 1'b0; blink_mask = '0;

    // 1: reset with load asserted
    step(); step();
    chk("rst_hex",   64'(hex_out), 64'h3FF_FFFF_FFFF);
    chk("rst_valid", 64'(disp_valid), 64'd0);
    chk("rst_phase", 64'(blink_phase), 64'd0);

    // 2: basic decode
    reset = 1'b0; load = 1'b1; value = 24'h0123AB;
    step();
    chk("valid_k", 64'(disp_valid), 64'd1);
    load = 1'b0;
    step();
    chk("dec_0123AB", 64'(hex_out), 64'({7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h03}));

    // 3: leading-zero blanking
    blank_lz = 1'b1; load = 1'b1; value = 24'h000A00;
    step(); load = 1'b0; step();
    chk("lz_000A00", 64'(hex_out), 64'({7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40, 7'h40}));
    load = 1'b1; value = 24'h0;
    step(); load = 1'b0; step();
    chk("lz_zero", 64'(hex_out), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}));

    // 4: blink digit 0
    blank_lz = 1'b0; load = 1'b1; value = 24'h000005;
    step(); load = 1'b0; step();
    blink_en = 1'b1; blink_mask = 6'b000001;
    step(); step(); step();
    chk("ph_pre",  64'(blink_phase), 64'd0);
    step();
    chk("ph_tog1", 64'(blink_phase), 64'd1);
    chk("d0_lit",  64'(dig(0)), 64'h12);
    step();
    chk("d0_dark", 64'(dig(0)), 64'h7F);
    chk("d1_lit",  64'(dig(1)), 64'h40);
    step(); step(); step();
    chk("ph_tog2", 64'(blink_phase), 64'd0);
    for (int i = 0; i < 5; i++) step();
    blink_en = 1'b0;
    step();
    chk("ph_off", 64'(blink_phase), 64'd0);
    step();
    chk("d0_steady", 64'(dig(0)), 64'h12);

    // 5: reset mid-blink
    blink_en = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("ph_mid", 64'(blink_phase), 64'd1);
    reset = 1'b1; blink_en = 1'b0;
    step();
    chk("rst2_hex",   64'(hex_out), 64'h3FF_FFFF_FFFF);
    chk("rst2_phase", 64'(blink_phase), 64'd0);
    reset = 1'b0; load = 1'b1; value = 24'h00000F;
    step(); load = 1'b0; step();
    chk("d0_F", 64'(dig(0)), 64'h0E);

    // 6: back-to-back loads
    load = 1'b1; value = 24'd1; step();
    value = 24'd2; step();
    chk("b2b_1", 64'(dig(0)), 64'h79);
    value = 24'd3; step();
    chk("b2b_2", 64'(dig(0)), 64'h24);
    load = 1'b0; step();
    chk("b2b_3", 64'(dig(0)), 64'h30);

    // random traffic against the model
    for (int n = 0; n < 200; n++) begin
      reset      = ($urandom_range(0, 29) == 0);
      load       = ($urandom_range(0, 2) == 0);
      value      = 24'($urandom >> $urandom_range(8, 31));
      blank_lz   = 1'($urandom_range(0, 1));
      blink_en   = ($urandom_range(0, 3) != 0);
      blink_mask = 6'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
